// File: rtl/rng_uniform_if.sv
// Purpose : handshake bundle between rng_uniform and its consumer (sample stream + reseed).
// Latency : none, plain wires.
// Backpressure: out_ready from the consumer holds out_valid/out_value in the source.
//
// Signals:
//   seed_load  consumer -> source  load seed_in into the LFSR this cycle
//   seed_in    consumer -> source  new seed (zero means "use the default seed")
//   out_ready  consumer -> source  consumer accepts out_value
//   out_valid  source -> consumer  out_value holds an unconsumed sample
//   out_value  source -> consumer  sample in 0..MAX_VALUE
interface rng_uniform_if #(
   parameter int WIDTH = 16,
   parameter int OUT_W = 5
);
   logic             seed_load;
   logic [WIDTH-1:0] seed_in;
   logic             out_ready;
   logic             out_valid;
   logic [OUT_W-1:0] out_value;

   // master: the random source
   modport master (
      input  seed_load,
      input  seed_in,
      input  out_ready,
      output out_valid,
      output out_value
   );

   // slave: the consumer of samples
   modport slave (
      output seed_load,
      output seed_in,
      output out_ready,
      input  out_valid,
      input  out_value
   );
endinterface

// File: rtl/rng_uniform.sv
// Purpose : uniform random values in 0..MAX_VALUE from a Fibonacci LFSR, using rejection sampling.
// Latency : first sample 1 cycle after reset release; each rejected candidate adds 1 cycle.
// Backpressure: sample holds while out_valid && !out_ready; the LFSR keeps stepping regardless.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   bus           rng_uniform_if.master (seed_load, seed_in, out_ready, out_valid, out_value)
//   reject_count  16-bit saturating count of rejected candidates
//                 (present only when RNG_REJECT_CNT_EN is defined)
//
// Parameters:
//   WIDTH      LFSR width (>= OUT_W, >= 2)
//   TAPS       feedback mask, bit i set means lfsr[i] feeds the XOR
//   MAX_VALUE  largest value emitted (>= 1)
//   SEED       reset and fallback LFSR state (non-zero)
// Optional feature macro: RNG_REJECT_CNT_EN
module rng_uniform #(
   parameter int unsigned      WIDTH     = 16,
   parameter logic [WIDTH-1:0] TAPS      = 16'hD008,
   parameter int unsigned      MAX_VALUE = 17,
   parameter logic [WIDTH-1:0] SEED      = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic          clk,
   input  logic          rst_n,
   rng_uniform_if.master bus
`ifdef RNG_REJECT_CNT_EN
   ,
   output logic [15:0]   reject_count
`endif
);

   localparam int OUT_W = $clog2(MAX_VALUE + 1);

   // Two-state view of the output slot.
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] lfsr;
   logic [WIDTH-1:0] lfsr_next;
   logic [WIDTH-1:0] seed_eff;
   logic [OUT_W-1:0] cand;
   logic             cand_ok;
   logic             slot_free;
   logic             out_valid_q;
   logic [OUT_W-1:0] out_value_q;

   // Next LFSR state. An all-zero register would stay stuck forever, so it is
   // pulled back to SEED; with a maximal-length TAPS this never triggers.
   always_comb begin
      lfsr_next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
      if (lfsr == '0) begin
         lfsr_next = SEED;
      end
   end

   // A zero seed would lock the LFSR, so it is replaced with SEED.
   assign seed_eff = (bus.seed_in == '0) ? SEED : bus.seed_in;

   // Candidate comes from the pre-shift state; values above MAX_VALUE are
   // thrown away rather than folded with a modulo, keeping the output uniform.
   assign cand    = lfsr[OUT_W-1:0];
   assign cand_ok = (cand <= OUT_W'(MAX_VALUE));

   // Slot can take a new sample if it is empty or is being drained this cycle.
   assign slot_free = !out_valid_q || bus.out_ready;

   // Slot FSM, LFSR and registered outputs. seed_load wins over everything:
   // the slot empties, out_value keeps its old contents, and a handshake in
   // the same cycle still counts as a completed transfer on the consumer side.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= EMPTY;
         lfsr        <= SEED;
         out_valid_q <= 1'b0;
         out_value_q <= '0;
      end else if (bus.seed_load) begin
         state       <= EMPTY;
         lfsr        <= seed_eff;
         out_valid_q <= 1'b0;
      end else begin
         // Free-running: steps even while the sample is stalled.
         lfsr <= lfsr_next;
         case (state)
            EMPTY: begin
               if (cand_ok) begin
                  state       <= FULL;
                  out_valid_q <= 1'b1;
                  out_value_q <= cand;
               end
            end
            FULL: begin
               if (bus.out_ready) begin
                  if (cand_ok) begin
                     out_value_q <= cand;
                  end else begin
                     state       <= EMPTY;
                     out_valid_q <= 1'b0;
                  end
               end
            end
            default: begin
               state       <= EMPTY;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_value = out_value_q;

`ifdef RNG_REJECT_CNT_EN
   // Saturating reject counter; survives seed_load, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reject_count <= '0;
      end else if (slot_free && !bus.seed_load && !cand_ok && (reject_count != 16'hFFFF)) begin
         reject_count <= reject_count + 16'd1;
      end
   end
`endif

endmodule
